data_mem_responder: RTL and testbench



---
 rtl/data_mem_responder_pkg.sv | 15 +
 rtl/data_mem_responder_if.sv | 26 ++
 rtl/data_mem_responder_bytelane_ram.sv | 31 +++
 rtl/data_mem_responder.sv | 119 +++++++++++
 tb/tb_data_mem_responder.sv | 180 ++++++++++++++++++
 5 files changed

// File: rtl/data_mem_responder_pkg.sv
// Shared constants for the data-memory responder: FSM encoding, data-segment
// base address and byte-lane count.
package data_mem_responder_pkg;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_e;

  // Data segment base, kept in step with the core's address map.
  localparam logic [31:0] DMEM_BASE_ADDR = 32'h1001_0000;

  localparam int NUM_LANES = 4;

endpackage

// File: rtl/data_mem_responder_if.sv
// Data-memory bus between the core datapath (master) and the responder (slave).
interface data_mem_responder_if;
  import data_mem_responder_pkg::*;

  logic [31:0]          iAddress;
  logic [31:0]          iWriteData;
  logic [NUM_LANES-1:0] iByteEnable;
  logic                 iWriteEnable;
  logic                 iReadEnable;
  logic                 iClearReq;
  logic [31:0]          oReadData;
  logic                 oBusy;
  logic                 oDrop;
  logic                 oRangeErr;

  modport master (
    output iAddress, iWriteData, iByteEnable, iWriteEnable, iReadEnable, iClearReq,
    input  oReadData, oBusy, oDrop, oRangeErr
  );

  modport slave (
    input  iAddress, iWriteData, iByteEnable, iWriteEnable, iReadEnable, iClearReq,
    output oReadData, oBusy, oDrop, oRangeErr
  );

endinterface

// File: rtl/data_mem_responder_bytelane_ram.sv
// Word-organised single-port RAM with per-byte write lanes and a read-first
// registered read port.
module bytelane_ram
  import data_mem_responder_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic                 iCLK,
  input  logic [NUM_LANES-1:0] we_i,
  input  logic                 re_i,
  input  logic [AW-1:0]        addr_i,
  input  logic [31:0]          wdata_i,
  output logic [31:0]          rdata_o
);

  logic [31:0] mem_q [DEPTH_WORDS];
  logic [31:0] rdata_q;

  // NOTE: the array and read register have no reset so they map onto block RAM;
  // the responder's clear engine is what zeroes the contents.
  always_ff @(posedge iCLK) begin
    if (re_i) rdata_q <= mem_q[addr_i];
    for (int n = 0; n < NUM_LANES; n++) begin
      if (we_i[n]) mem_q[addr_i][8*n +: 8] <= wdata_i[8*n +: 8];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/data_mem_responder.sv
// Slave end of the multicycle core's data-memory bus: window decode, post-reset
// clear engine, byte-lane RAM and drop / range-error reporting.
module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = DMEM_BASE_ADDR,
  parameter int          DEPTH_WORDS = 1024,
  localparam int         AW          = $clog2(DEPTH_WORDS)
) (
  input logic                 iCLK,
  input logic                 iRST,
  data_mem_responder_if.slave bus
);

  localparam logic [32:0]   WIN_LO   = {1'b0, BASE_ADDR};
  localparam logic [32:0]   WIN_HI   = WIN_LO + 33'(NUM_LANES * DEPTH_WORDS);
  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH_WORDS - 1);

  state_e               state_q, state_d;
  logic [AW-1:0]        cnt_q, cnt_d;
  logic                 drop_q, drop_d;
  logic                 err_q, err_d;
  logic                 rd_valid_q, rd_valid_d;

  logic [32:0]          addr_ext;
  logic                 hit;
  logic                 access;
  logic [AW-1:0]        idx;

  logic [NUM_LANES-1:0] ram_we;
  logic                 ram_re;
  logic [AW-1:0]        ram_addr;
  logic [31:0]          ram_wdata;
  logic [31:0]          ram_rdata;

  // 33-bit compare keeps the window from wrapping at the top of the address space.
  assign addr_ext = {1'b0, bus.iAddress};
  assign hit      = (addr_ext >= WIN_LO) && (addr_ext < WIN_HI);
  assign idx      = bus.iAddress[AW+1:2] - BASE_ADDR[AW+1:2];
  assign access   = bus.iWriteEnable || bus.iReadEnable;

  // NOTE: every signal written here gets a default first, so no latch is inferred.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    drop_d     = 1'b0;
    err_d      = err_q;
    rd_valid_d = rd_valid_q;
    ram_we     = '0;
    ram_re     = 1'b0;
    ram_addr   = idx;
    ram_wdata  = bus.iWriteData;

    case (state_q)
      ST_CLEAR: begin
        // Clear engine owns the write port; core accesses are discarded.
        ram_we    = '1;
        ram_addr  = cnt_q;
        ram_wdata = '0;
        cnt_d     = cnt_q + AW'(1);
        if (cnt_q == LAST_IDX) state_d = ST_READY;
        drop_d    = access;
        if (bus.iReadEnable) rd_valid_d = 1'b0;
      end
      ST_READY: begin
        if (bus.iWriteEnable && hit) ram_we = bus.iByteEnable;
        ram_re = bus.iReadEnable && hit;
        if (bus.iReadEnable) rd_valid_d = hit;
        if (access && !hit) begin
          drop_d = 1'b1;
          err_d  = 1'b1;
        end
        if (bus.iClearReq) begin
          state_d = ST_CLEAR;
          cnt_d   = '0;
        end
      end
      default: state_d = ST_CLEAR;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values and the update order inside the block does not matter.
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      state_q    <= ST_CLEAR;
      cnt_q      <= '0;
      drop_q     <= 1'b0;
      err_q      <= 1'b0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      drop_q     <= drop_d;
      err_q      <= err_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  bytelane_ram #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .AW          (AW)
  ) u_ram (
    .iCLK    (iCLK),
    .we_i    (ram_we),
    .re_i    (ram_re),
    .addr_i  (ram_addr),
    .wdata_i (ram_wdata),
    .rdata_o (ram_rdata)
  );

  // rd_valid_q gates the un-reset RAM register, giving zero after reset, misses
  // and reads during clear while still holding when no read is issued.
  assign bus.oReadData = rd_valid_q ? ram_rdata : '0;
  assign bus.oBusy     = (state_q == ST_CLEAR);
  assign bus.oDrop     = drop_q;
  assign bus.oRangeErr = err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder: a word-array model predicts read data,
// drop pulses and the sticky range error for every access.
module tb_data_mem_responder;

  localparam int          DEPTH = 1024;
  localparam logic [31:0] BASE  = 32'h1001_0000;

  logic iCLK = 1'b0;
  logic iRST = 1'b1;

  data_mem_responder_if bus();

  data_mem_responder #(
    .BASE_ADDR   (BASE),
    .DEPTH_WORDS (DEPTH)
  ) dut (
    .iCLK (iCLK),
    .iRST (iRST),
    .bus  (bus)
  );

  always #5 iCLK = ~iCLK;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] model_mem [DEPTH];
  logic        model_ready = 1'b0;
  logic        model_err   = 1'b0;
  logic [31:0] exp_q [$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic in_window(input logic [31:0] a);
    logic [32:0] lo;
    lo = {1'b0, BASE};
    return ({1'b0, a} >= lo) && ({1'b0, a} < lo + 33'(4 * DEPTH));
  endfunction

  function automatic int word_of(input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE;
    return int'(off[11:2]);
  endfunction

  task automatic tick();
    @(posedge iCLK);
    #1;
  endtask

  // One bus cycle: predict, drive, advance one edge, then compare outputs.
  task automatic access(input string tag, input logic we, input logic re,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] be, input logic clr);
    logic        hit;
    logic        exp_drop;
    logic [31:0] exp_rd;
    hit = in_window(addr);
    bus.iAddress     = addr;
    bus.iWriteData   = wdata;
    bus.iByteEnable  = be;
    bus.iWriteEnable = we;
    bus.iReadEnable  = re;
    bus.iClearReq    = clr;
    if (re) exp_q.push_back((model_ready && hit) ? model_mem[word_of(addr)] : 32'h0);
    if (model_ready && hit && we) begin
      for (int n = 0; n < 4; n++)
        if (be[n]) model_mem[word_of(addr)][8*n +: 8] = wdata[8*n +: 8];
    end
    exp_drop = (we || re) && !(model_ready && hit);
    if (model_ready && !hit && (we || re)) model_err = 1'b1;
    tick();
    bus.iWriteEnable = 1'b0;
    bus.iReadEnable  = 1'b0;
    bus.iClearReq    = 1'b0;
    if (re) begin
      exp_rd = exp_q.pop_front();
      check({tag, "_rdata"}, bus.oReadData, exp_rd);
    end
    check({tag, "_drop"}, 32'(bus.oDrop), 32'(exp_drop));
    check({tag, "_rerr"}, 32'(bus.oRangeErr), 32'(model_err));
  endtask

  // Counts edges until oBusy falls (bounded), then marks the model cleared.
  task automatic wait_clear(input string tag, input int already);
    int n;
    n = already;
    while (bus.oBusy && n < 2000) begin
      tick();
      n++;
    end
    check(tag, 32'(n), 32'd1024);
    for (int i = 0; i < DEPTH; i++) model_mem[i] = 32'h0;
    model_ready = 1'b1;
  endtask

  initial begin
    bus.iAddress     = '0;
    bus.iWriteData   = '0;
    bus.iByteEnable  = '0;
    bus.iWriteEnable = 1'b0;
    bus.iReadEnable  = 1'b0;
    bus.iClearReq    = 1'b0;

    // Reset values
    repeat (2) tick();
    check("rst_busy",  32'(bus.oBusy),     32'd1);
    check("rst_rdata", bus.oReadData,      32'h0);
    check("rst_drop",  32'(bus.oDrop),     32'd0);
    check("rst_rerr",  32'(bus.oRangeErr), 32'd0);

    // Post-reset clear, with accesses on clear cycles 5 and 6
    iRST = 1'b0;
    repeat (4) tick();
    access("clr_wr", 1'b1, 1'b0, BASE + 32'h4, 32'hAAAA_AAAA, 4'hF, 1'b0);
    check("clr_busy", 32'(bus.oBusy), 32'd1);
    access("clr_rd", 1'b0, 1'b1, BASE + 32'h8, 32'h0, 4'h0, 1'b0);
    wait_clear("clear_len", 6);
    check("idle_drop", 32'(bus.oDrop), 32'd0);
    access("rd_top",     1'b0, 1'b1, BASE + 32'hFFC, 32'h0, 4'h0, 1'b0);
    access("rd_dropped", 1'b0, 1'b1, BASE + 32'h4,   32'h0, 4'h0, 1'b0);

    // Word then byte write
    access("wr_word",  1'b1, 1'b0, BASE + 32'h10, 32'hDEAD_BEEF, 4'b1111, 1'b0);
    access("wr_byte",  1'b1, 1'b0, BASE + 32'h10, 32'h0000_5500, 4'b0010, 1'b0);
    access("rd_merge", 1'b0, 1'b1, BASE + 32'h10, 32'h0, 4'h0, 1'b0);
    check("merge_const", bus.oReadData, 32'hDEAD_55EF);
    access("wr_nobe",  1'b1, 1'b0, BASE + 32'h10, 32'hFFFF_FFFF, 4'b0000, 1'b0);
    access("rd_nobe",  1'b0, 1'b1, BASE + 32'h10, 32'h0, 4'h0, 1'b0);
    tick();
    check("rd_hold", bus.oReadData, 32'hDEAD_55EF);

    // Same-word read and write: read-first
    access("wr_1111", 1'b1, 1'b0, BASE + 32'h20, 32'h1111_1111, 4'hF, 1'b0);
    access("rw_same", 1'b1, 1'b1, BASE + 32'h20, 32'h2222_2222, 4'hF, 1'b0);
    check("rw_const", bus.oReadData, 32'h1111_1111);
    access("rd_2222", 1'b0, 1'b1, BASE + 32'h20, 32'h0, 4'h0, 1'b0);

    // Out-of-window accesses, both edges of the window and the 2^32 wrap
    access("oor_wr",   1'b1, 1'b0, 32'h1000_FFFC, 32'hFFFF_FFFF, 4'hF, 1'b0);
    access("oor_rd",   1'b0, 1'b1, 32'h1001_1000, 32'h0, 4'h0, 1'b0);
    access("oor_wrap", 1'b0, 1'b1, 32'hFFFF_FFFC, 32'h0, 4'h0, 1'b0);
    access("chk_base", 1'b0, 1'b1, BASE,          32'h0, 4'h0, 1'b0);
    access("chk_top",  1'b0, 1'b1, BASE + 32'hFFC, 32'h0, 4'h0, 1'b0);

    // Clear request with a concurrent write
    access("clrreq", 1'b1, 1'b0, BASE + 32'h30, 32'h1234_5678, 4'hF, 1'b1);
    model_ready = 1'b0;
    check("clrreq_busy", 32'(bus.oBusy), 32'd1);
    access("clr2_rd", 1'b0, 1'b1, BASE + 32'h30, 32'h0, 4'h0, 1'b0);
    wait_clear("clear2_len", 1);
    access("rd_cleared", 1'b0, 1'b1, BASE + 32'h30, 32'h0, 4'h0, 1'b0);

    // Reset in the middle of a clear
    access("wr_5a", 1'b1, 1'b0, BASE + 32'h40, 32'h5A5A_5A5A, 4'hF, 1'b0);
    access("clrreq2", 1'b0, 1'b0, BASE, 32'h0, 4'h0, 1'b1);
    model_ready = 1'b0;
    repeat (500) tick();
    iRST = 1'b1;
    #1;
    model_err = 1'b0;
    check("midrst_busy",  32'(bus.oBusy),     32'd1);
    check("midrst_rerr",  32'(bus.oRangeErr), 32'd0);
    check("midrst_rdata", bus.oReadData,      32'h0);
    tick();
    iRST = 1'b0;
    wait_clear("rst_clear_len", 0);
    check("post_rst_rerr", 32'(bus.oRangeErr), 32'd0);
    access("rd_5a", 1'b0, 1'b1, BASE + 32'h40, 32'h0, 4'h0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
